// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its debounce stage.
package keypad_pkg;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM,
        HELD,
        RELEASING
    } deb_state_t;
endpackage

// File: rtl/key_debounce.sv
// Debounce FSM evaluated once per completed keypad scan; emits one press event per
// qualified key press and a debounced "key held" level.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       scan_done,
    input  logic       scan_valid,
    input  key_code_t  scan_code,
    output logic       press_evt,
    output logic       pressed,
    output key_code_t  code,
    output deb_state_t dbg_state
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    deb_state_t       state_q, state_d;
    key_code_t        cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;

    logic             same;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        evt_d    = 1'b0;
        same     = scan_valid && (scan_code == cand_q);
        cnt_inc  = cnt_q + CNT_W'(1);
        cnt_full = (int'(cnt_q) + 1) >= DEBOUNCE_SCANS;
        if (scan_done) begin
            case (state_q)
                RELEASED: begin
                    if (scan_valid) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = HELD;
                            evt_d   = 1'b1;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (!scan_valid) begin
                        state_d = RELEASED;
                    end else if (same) begin
                        cnt_d = cnt_inc;
                        if (cnt_full) begin
                            state_d = HELD;
                            evt_d   = 1'b1;
                        end
                    end else begin
                        cand_d = scan_code;
                        cnt_d  = CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!same) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? RELEASED : RELEASING;
                    end
                end
                RELEASING: begin
                    // The held key coming back is a bounce, not a new press.
                    if (same) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_full) state_d = RELEASED;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RELEASED;
            cand_q  <= '0;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign press_evt = evt_q;
    assign pressed   = (state_q == HELD) || (state_q == RELEASING);
    assign code      = cand_q;
    assign dbg_state = state_q;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column stepping, row synchronisation, per-scan
// single-key evaluation, debounce and a valid/ack output register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output key_code_t           o_key,
    output logic                o_valid,
    input  logic                i_ack,
    output logic                o_pressed,
    output logic                o_overrun
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [NUM_ROWS-1:0] rows_s1_q, rows_s1_d, rows_s2_q, rows_s2_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          col_q, col_d;
    logic [1:0]          hit_cnt_q, hit_cnt_d;
    key_code_t           hit_code_q, hit_code_d;
    key_code_t           key_q, key_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;

    logic                tc;
    logic [NUM_ROWS-1:0] row_low;
    logic [2:0]          ones;
    logic [2:0]          sum;
    logic [1:0]          row_idx;
    key_code_t           code_new;
    logic                scan_done, scan_valid;
    key_code_t           scan_code;
    logic                press_evt, deb_pressed, ack;
    key_code_t           deb_code;
    deb_state_t          deb_state;

    always_comb begin
        rows_s1_d = rows;
        rows_s2_d = rows_s1_q;
        tc        = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d     = tc ? '0 : div_q + DIV_W'(1);
        col_d     = tc ? col_q + 2'd1 : col_q;

        row_low = ~rows_s2_q;
        ones    = '0;
        row_idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            ones = ones + 3'(row_low[i]);
            if (row_low[i]) row_idx = 2'(i);
        end
        // Hits saturate at 2: anything beyond one pressed position is rejected.
        sum      = 3'(hit_cnt_q) + ones;
        code_new = (ones == 3'd1 && hit_cnt_q == 2'd0) ? {col_q, row_idx} : hit_code_q;

        hit_cnt_d  = hit_cnt_q;
        hit_code_d = hit_code_q;
        scan_done  = 1'b0;
        scan_valid = 1'b0;
        scan_code  = code_new;
        if (tc) begin
            if (col_q == 2'(NUM_COLS - 1)) begin
                scan_done  = 1'b1;
                scan_valid = (sum == 3'd1);
                hit_cnt_d  = '0;
                hit_code_d = '0;
            end else begin
                hit_cnt_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
                hit_code_d = code_new;
            end
        end

        // o_valid/i_ack: a key is offered while o_valid=1 and o_key is frozen until
        // the edge where i_ack=1 retires it; a press arriving while an offer is
        // still unacknowledged is dropped and latched in o_overrun.
        ack     = valid_q && i_ack;
        valid_d = valid_q;
        key_d   = key_q;
        ovr_d   = ovr_q;
        if (ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (press_evt) begin
            if (!valid_q || ack) begin
                key_d   = deb_code;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rows_s1_q  <= '1;
            rows_s2_q  <= '1;
            div_q      <= '0;
            col_q      <= '0;
            hit_cnt_q  <= '0;
            hit_code_q <= '0;
            key_q      <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rows_s1_q  <= rows_s1_d;
            rows_s2_q  <= rows_s2_d;
            div_q      <= div_d;
            col_q      <= col_d;
            hit_cnt_q  <= hit_cnt_d;
            hit_code_q <= hit_code_d;
            key_q      <= key_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clock     (clock),
        .i_reset   (i_reset),
        .scan_done (scan_done),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .press_evt (press_evt),
        .pressed   (deb_pressed),
        .code      (deb_code),
        .dbg_state (deb_state)
    );

    a_pressed_tracks_state: assert property (@(posedge clock) disable iff (!i_reset)
        deb_pressed == ((deb_state == HELD) || (deb_state == RELEASING)));

    assign cols      = ~(NUM_COLS'(1) << col_q);
    assign o_key     = key_q;
    assign o_valid   = valid_q;
    assign o_pressed = deb_pressed;
    assign o_overrun = ovr_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=2, one scan = 16 cycles)
// with a keypad matrix model and a queue-based key scoreboard.
module tb_keypad_scan;
    import keypad_pkg::*;

    logic       clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_ack = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    key_code_t  o_key;
    logic       o_valid, o_pressed, o_overrun;

    logic [15:0] keys = '0;
    int          checks = 0;
    int          failures = 0;
    int          pos = 0;
    logic        prev_v = 1'b0;
    logic [3:0]  mon_exp;
    logic [3:0]  exp_q[$];

    keypad_scan #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .rows     (rows),
        .cols     (cols),
        .o_key    (o_key),
        .o_valid  (o_valid),
        .i_ack    (i_ack),
        .o_pressed(o_pressed),
        .o_overrun(o_overrun)
    );

    always #5 clock = ~clock;

    // Key (c,r) shorts column c to row r; rows idle high through the pull-ups.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!cols[c] && keys[c*4+r]) rows[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (pos=%0d)", name, act, exp, pos);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        pos++;
    endtask

    task automatic scans(input int n);
        repeat (16 * n) tick();
    endtask

    task automatic to_boundary();
        while (pos % 16 != 0) tick();
    endtask

    task automatic ack_pulse();
        int n = 0;
        while (!o_valid && n < 64) begin
            tick();
            n++;
        end
        check("ack_wait_valid", o_valid, 1);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        check("ack_clears_valid", o_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cols"}, cols, 4'b1110);
        check({tag, "_key"}, o_key, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_pressed"}, o_pressed, 0);
        check({tag, "_overrun"}, o_overrun, 0);
    endtask

    // Monitor: every new offer on o_valid is matched against the next expected key.
    always @(negedge clock) begin
        if (o_valid && !prev_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: o_key=%0d offered with no press expected (pos=%0d)", o_key, pos);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_key !== mon_exp) begin
                    failures++;
                    $display("FAIL event_key: got %0d expected %0d (pos=%0d)", o_key, mon_exp, pos);
                end
            end
        end
        prev_v = o_valid;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [3:0] ec;
        int idx;

        // 1. reset values, then column stepping every 4 cycles with wrap
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        i_reset = 1'b1;
        pos = 0;
        for (int k = 0; k <= 16; k++) begin
            idx = (pos / 4) % 4;
            ec = ~(4'b0001 << idx);
            check("cols_step", cols, ec);
            if (k < 16) tick();
        end

        // 2. key (2,1) = 9: event after 2nd scan, ack, no auto-repeat
        keys[9] = 1'b1;
        exp_q.push_back(4'd9);
        scans(2);
        check("t2_not_yet_valid", o_valid, 0);
        tick();
        check("t2_valid", o_valid, 1);
        check("t2_key", o_key, 9);
        check("t2_pressed", o_pressed, 1);
        ack_pulse();
        to_boundary();
        scans(3);
        check("t2_still_pressed", o_pressed, 1);
        check("t2_no_repeat", o_valid, 0);
        keys = '0;
        scans(2);
        check("t2_released", o_pressed, 0);

        // 3. bounce on key (0,3) = 3, then an isolated 1-scan press
        keys[3] = 1'b1;
        exp_q.push_back(4'd3);
        scans(1);
        keys = '0;
        scans(1);
        keys[3] = 1'b1;
        scans(3);
        check("t3_valid", o_valid, 1);
        check("t3_key", o_key, 3);
        ack_pulse();
        to_boundary();
        keys = '0;
        scans(3);
        check("t3_released", o_pressed, 0);
        keys[3] = 1'b1;
        scans(1);
        keys = '0;
        scans(2);
        check("t3_short_no_valid", o_valid, 0);
        check("t3_short_no_pressed", o_pressed, 0);

        // 4. two keys together are rejected
        keys[4] = 1'b1;
        keys[14] = 1'b1;
        scans(4);
        check("t4_no_valid", o_valid, 0);
        check("t4_no_pressed", o_pressed, 0);
        keys = '0;
        scans(1);

        // 5. overrun: key 5 pending, key 12 dropped
        keys[5] = 1'b1;
        exp_q.push_back(4'd5);
        scans(2);
        keys = '0;
        scans(2);
        keys[12] = 1'b1;
        scans(2);
        tick();
        check("t5_valid_held", o_valid, 1);
        check("t5_key_kept", o_key, 5);
        check("t5_overrun", o_overrun, 1);
        keys = '0;
        to_boundary();
        scans(2);
        check("t5_overrun_sticky", o_overrun, 1);
        ack_pulse();
        check("t5_overrun_cleared", o_overrun, 0);
        to_boundary();

        // 6. async reset while HELD with a pending key, then re-qualification
        keys[6] = 1'b1;
        exp_q.push_back(4'd6);
        scans(2);
        tick();
        check("t6_valid", o_valid, 1);
        check("t6_pressed", o_pressed, 1);
        @(negedge clock);
        #1;
        i_reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(negedge clock);
        i_reset = 1'b1;
        pos = 0;
        exp_q.push_back(4'd6);
        scans(1);
        check("t6_requalify_no_valid", o_valid, 0);
        check("t6_requalify_no_pressed", o_pressed, 0);
        scans(1);
        tick();
        check("t6_revalid", o_valid, 1);
        check("t6_rekey", o_key, 6);
        ack_pulse();
        keys = '0;
        to_boundary();
        scans(2);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
